// File: rtl/fetch_pkg.sv
// Shared widths and the FIFO entry layout for the instruction fetch buffer.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with a flush that empties it in one cycle.
// Pushes into a full FIFO and pops from an empty one are ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  entry_t                   wdata_i,
  output entry_t                   rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_MAX);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Owns the fetch PC, captures {pc, word} from memory into a FIFO and hands
// entries to decode over valid/ready; a redirect flushes and restarts fetch.
module instruction_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [ADDR_W-1:0]      fetch_pc_q, fetch_pc_d;
  logic                   push, pop, fifo_empty, fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t           wr_entry, head_entry;

  // Redirect suppresses both push and pop so nothing from the old stream survives.
  assign push = !fifo_full && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign wr_entry    = '{pc: fetch_pc_q, instr: mem_data};
  assign mem_address = fetch_pc_q;
  assign out_valid   = !fifo_empty;
  assign out_pc      = head_entry.pc;
  assign out_instr   = head_entry.instr;

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc;
    else if (push)      fetch_pc_d = fetch_pc_q + PC_STEP;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer with a memory model mem[a] = a + 100.
module tb_instruction_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Combinational memory preloaded so that mem[a] = a + 100.
  assign mem_data = mem_address + 32'd100;

  instruction_fetch_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Advance one cycle; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic expect_head(input string name, input logic [31:0] pc);
    total++;
    if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== pc + 32'd100) begin
      bad++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h, want valid=1 pc=%h instr=%h",
               name, out_valid, out_pc, out_instr, pc, pc + 32'd100);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0 || mem_address !== 32'd0 || dut.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got valid=%0b addr=%h count=%0d, want 0/0/0",
               out_valid, mem_address, dut.fifo_count);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_pre_edge: got valid=%0b want 0", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_head($sformatf("stream_%0d", i), i);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    repeat (10) tick();
    total++;
    if (dut.fifo_count !== 3'd4 || mem_address !== 32'd4) begin
      bad++;
      $display("FAIL stall_full: got count=%0d addr=%h, want count=4 addr=4",
               dut.fifo_count, mem_address);
    end
    expect_head("stall_head", 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      tick();
      expect_head($sformatf("drain_%0d", i), i);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    total++;
    if (dut.fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL redirect_prefill: got count=%0d want 3", dut.fifo_count);
    end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd20;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || mem_address !== 32'd20) begin
      bad++;
      $display("FAIL redirect_flush: got valid=%0b addr=%h, want valid=0 addr=14",
               out_valid, mem_address);
    end
    tick();
    expect_head("redirect_first", 32'd20);
    tick();
    expect_head("redirect_second", 32'd21);
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || mem_address !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL wrap_flush: got valid=%0b addr=%h, want valid=0 addr=fffffffe",
               out_valid, mem_address);
    end
    tick();
    expect_head("wrap_fffffffe", 32'hFFFF_FFFE);
    tick();
    expect_head("wrap_ffffffff", 32'hFFFF_FFFF);
    tick();
    expect_head("wrap_00000000", 32'h0000_0000);
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    repeat (2) tick();
    expect_head("midreset_buffered", 32'd0);
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || mem_address !== 32'd0) begin
      bad++;
      $display("FAIL midreset_async: got valid=%0b addr=%h, want valid=0 addr=0",
               out_valid, mem_address);
    end
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    expect_head("midreset_restart_0", 32'd0);
    tick();
    expect_head("midreset_restart_1", 32'd1);
  endtask

  task automatic test_random_ready();
    logic [31:0] exp_pc;
    int          accepted;
    logic        count_ok;
    exp_pc = 32'd0;
    accepted = 0;
    count_ok = 1'b1;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (dut.fifo_count > 3'd4) count_ok = 1'b0;
      if (out_valid && out_ready) begin
        total++;
        if (out_pc !== exp_pc || out_instr !== exp_pc + 32'd100) begin
          bad++;
          $display("FAIL random_accept_%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                   accepted, out_pc, out_instr, exp_pc, exp_pc + 32'd100);
        end
        exp_pc = exp_pc + 32'd1;
        accepted++;
      end
      tick();
    end
    total++;
    if (!count_ok || accepted < 50) begin
      bad++;
      $display("FAIL random_summary: got count_ok=%0b accepted=%0d, want 1 and >=50",
               count_ok, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_mid_reset();
    test_random_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Downstream consumer of `program_counter` + `simple_memory`: owns the fetch PC, drives the memory address, and captures each returned word with its PC into a small FIFO. Presents fetched instructions to the decode stage over a valid/ready handshake. Decouples decode stalls from fetch, and flushes on a PC redirect (branch/jump) from later stages.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `RESET_PC`, 32'd0, first fetch address after reset
- `PC_STEP`, 32'd1, address increment per fetch (word-addressed memory)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `mem_address`  out  32  address to `simple_memory`; equals internal fetch PC
- `mem_data`  in  32  combinational read data for `mem_address`, same cycle
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new fetch address
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  decode accepts head entry
- `out_instr`  out  32  head entry instruction word
- `out_pc`  out  32  head entry PC

## Operation
- State: `fetch_pc`, FIFO storage of {pc, instr}, read/write pointers, `count` (0..DEPTH).
- `mem_address = fetch_pc` at all times, combinational from the register.
- Push: when `count < DEPTH` and `redirect_valid` = 0, write {`fetch_pc`, `mem_data`} at the write pointer and advance `fetch_pc` by `PC_STEP`.
- No push when `count == DEPTH`, even if a pop occurs that cycle; `fetch_pc` holds.
- Pop: when `out_valid && out_ready` and `redirect_valid` = 0, advance the read pointer.
- Simultaneous push and pop (count < DEPTH): `count` unchanged, both pointers advance.
- Redirect has priority over everything:
  - `count` ← 0 and both pointers ← 0.
  - `fetch_pc` ← `redirect_pc`.
  - No push, no pop that cycle, even if `out_ready` = 1.
- `out_valid = (count != 0)`; `out_instr`/`out_pc` come combinationally from the head entry. They are don't-care when `out_valid` = 0.
- Arithmetic: `fetch_pc + PC_STEP` is 32-bit and wraps modulo 2^32 (0xFFFFFFFF + 1 → 0). `count` is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Entries leave in strict fetch order; no entry is duplicated or dropped except by redirect.

## Timing
- Reset (reset = 0, any time, asynchronous):
  - `fetch_pc` = RESET_PC, `count` = 0, pointers = 0.
  - Outputs: `out_valid` = 0, `mem_address` = RESET_PC.
  - FIFO data contents are not reset.
- Reset mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- First edge after reset release pushes {RESET_PC, mem[RESET_PC]}. `out_valid` = 1 after that edge, i.e. 1-cycle fetch-to-decode latency.
- Redirect asserted in cycle N:
  - After edge N, `out_valid` = 0 and `mem_address` = `redirect_pc`.
  - After edge N+1, head = {`redirect_pc`, mem[`redirect_pc`]}.
- Decode held at `out_ready` = 0 from reset: the FIFO fills in DEPTH cycles, then `fetch_pc` freezes at RESET_PC + DEPTH·PC_STEP.
- Steady state with `out_ready` = 1 and count < DEPTH: one instruction per cycle.

## Structure
- Package `fetch_pkg`:
  - `ADDR_W` = 32 and `DATA_W` = 32.
  - `typedef struct packed { logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] instr; } fetch_entry_t`.
- Sub-module `fetch_fifo`: parameterised by DEPTH and element type `fetch_entry_t`.
  - Push/pop/flush inputs; count/empty/full outputs.
  - Same asynchronous active-low reset.
- Top level holds `fetch_pc`, redirect priority logic and the handshake.
- Bench pairs the block with `simple_memory`, preloaded so that mem[a] = a + 100.

## Test plan
- Reset then `out_ready` = 1 continuously → consecutive accepted pairs (0,100), (1,101), (2,102), …; one per cycle, first pair valid 1 cycle after reset release.
- `out_ready` = 0 for 10 cycles after reset:
  - `count` = 4 and `mem_address` holds at 4.
  - Then `out_ready` = 1 → (0,100)…(3,103) in order, followed by (4,104) with no gap or duplicate.
- Redirect to 20 while 3 entries are buffered and `out_ready` = 1:
  - No pop that cycle; `out_valid` = 0 next cycle.
  - Then (20,120), (21,121).
- Redirect to 0xFFFFFFFE with PC_STEP = 1 → outputs PCs 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- `reset` = 0 mid-stream with 2 entries buffered:
  - `out_valid` drops immediately, before the next edge.
  - After release, the stream restarts at (0,100).
- Random `out_ready` toggling for 200 cycles → the accepted PC sequence is strictly +1 with no loss; `count` never exceeds 4.
